// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port RV32I data memory slave with valid/ready
// request and response channels, a configurable number of wait states and
// byte/halfword/word loads and stores with alignment and range checking.
module data_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic             accept;
  logic             enter_resp;
  logic             cur_we;
  logic [2:0]       cur_f3;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_in_range;
  logic [31:0]      cur_word;
  logic             cur_err;

  // Illegal encodings, misalignment and out-of-range addresses (full 32-bit compare).
  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic bad;
    case (f3)
      3'b000:         bad = 1'b0;
      3'b001:         bad = addr[0];
      3'b010:         bad = (addr[1:0] != 2'b00);
      3'b100, 3'b101: bad = we;
      default:        bad = 1'b1;
    endcase
    return bad || (addr >= ADDR_LIMIT);
  endfunction

  // Select the addressed lane(s) of a word and sign/zero extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'd0, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      3'b010:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Merge right-aligned store data into the old word on the addressed lanes only.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] rep;
    logic [3:0]  mask;
    logic [31:0] res;
    case (f3[1:0])
      2'b00: begin
        rep  = {4{wd[7:0]}};
        mask = 4'b0001 << lane;
      end
      2'b01: begin
        rep  = {2{wd[15:0]}};
        mask = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        rep  = wd;
        mask = 4'b1111;
      end
    endcase
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = rep[8*b +: 8];
    end
    return res;
  endfunction

  assign accept = req_valid && ready_q;

  // In IDLE the live request is what gets executed (zero wait states); otherwise the captured one.
  always_comb begin
    cur_we       = we_q;
    cur_f3       = f3_q;
    cur_addr     = addr_q;
    cur_wdata    = wdata_q;
    if (state_q == S_IDLE) begin
      cur_we    = req_we;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
    cur_idx      = cur_addr[IDX_W+1:2];
    cur_in_range = (cur_addr < ADDR_LIMIT);
    cur_word     = cur_in_range ? mem_q[cur_idx] : 32'd0;
    cur_err      = is_illegal(cur_we, cur_f3, cur_addr);
  end

  // Next-state logic, request capture, and memory access on entry to RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_d   = mem_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_we) ? 32'd0 : load_extend(cur_word, cur_f3, cur_addr[1:0]);
      if (cur_we && !cur_err) begin
        mem_d[cur_idx] = store_merge(cur_word, cur_wdata, cur_f3, cur_addr[1:0]);
      end
    end

    // Ready is registered so it stays low through reset and on the RESP->IDLE edge.
    ready_d = (state_d == S_IDLE);
  end

  // State, capture, response and memory registers; everything clears while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
